// File: rtl/memory_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: FSM states, owner
// encoding and the round-robin pick used when both requesters contend.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DMA = 1'b1
    } owner_t;

    // Round-robin pick: on contention the requester that did not win last time gets the port.
    function automatic owner_t rr_pick(input logic cpu_req, input logic dma_req,
                                       input owner_t last_owner);
        if (cpu_req && dma_req) begin
            return (last_owner == OWNER_CPU) ? OWNER_DMA : OWNER_CPU;
        end else if (cpu_req) begin
            return OWNER_CPU;
        end else begin
            return OWNER_DMA;
        end
    endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Two-requester (CPU / DMA) memory port arbiter. A request is latched in
// IDLE, presented to memory during ACCESS until mem_ready or a timeout, and
// acknowledged with a single RESP cycle before returning to IDLE.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    owner_t            owner_reg, owner_next;
    owner_t            last_owner_reg, last_owner_next;
    owner_t            grant;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              err_reg, err_next;
    logic [DATA_W-1:0] cpu_rdata_reg, cpu_rdata_next;
    logic [DATA_W-1:0] dma_rdata_reg, dma_rdata_next;

    assign grant     = rr_pick(cpu_req, dma_req, last_owner_reg);
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign cpu_rdata = cpu_rdata_reg;
    assign dma_rdata = dma_rdata_reg;

    // State and datapath registers; reset clears everything and favours the CPU next.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            owner_reg      <= OWNER_CPU;
            last_owner_reg <= OWNER_DMA;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            cnt_reg        <= '0;
            err_reg        <= 1'b0;
            cpu_rdata_reg  <= '0;
            dma_rdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            cnt_reg        <= cnt_next;
            err_reg        <= err_next;
            cpu_rdata_reg  <= cpu_rdata_next;
            dma_rdata_reg  <= dma_rdata_next;
        end
    end

    // Next-state, request latching, timeout counting and port outputs.
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        cnt_next        = cnt_reg;
        err_next        = err_reg;
        cpu_rdata_next  = cpu_rdata_reg;
        dma_rdata_next  = dma_rdata_reg;
        cpu_gnt         = 1'b0;
        dma_gnt         = 1'b0;
        cpu_ack         = 1'b0;
        dma_ack         = 1'b0;
        err             = 1'b0;
        mem_en          = 1'b0;
        mem_write       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    owner_next      = grant;
                    last_owner_next = grant;
                    we_next         = (grant == OWNER_DMA) ? dma_we    : cpu_we;
                    addr_next       = (grant == OWNER_DMA) ? dma_addr  : cpu_addr;
                    wdata_next      = (grant == OWNER_DMA) ? dma_wdata : cpu_wdata;
                    cnt_next        = '0;
                    err_next        = 1'b0;
                    state_next      = ACCESS;
                end
            end

            ACCESS: begin
                cpu_gnt   = (owner_reg == OWNER_CPU);
                dma_gnt   = (owner_reg == OWNER_DMA);
                mem_en    = 1'b1;
                mem_write = we_reg;
                if (mem_ready) begin
                    // Only reads update the requester's read-data register.
                    if (!we_reg) begin
                        if (owner_reg == OWNER_DMA) dma_rdata_next = mem_rdata;
                        else                        cpu_rdata_next = mem_rdata;
                    end
                    state_next = RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    // Abort: a timed-out read returns zero.
                    err_next = 1'b1;
                    if (!we_reg) begin
                        if (owner_reg == OWNER_DMA) dma_rdata_next = '0;
                        else                        cpu_rdata_next = '0;
                    end
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            RESP: begin
                cpu_gnt    = (owner_reg == OWNER_CPU);
                dma_gnt    = (owner_reg == OWNER_DMA);
                cpu_ack    = (owner_reg == OWNER_CPU);
                dma_ack    = (owner_reg == OWNER_DMA);
                err        = err_reg;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: table-driven single transactions,
// plus hand-written contention and reset-abort sequences. Completions are
// checked against a scoreboard queue filled when stimulus is driven.
module tb_memory_arbiter;

    localparam int TIMEOUT = 15;
    localparam int NEVER   = 99;

    logic       clock;
    logic       reset;
    logic       cpu_req, cpu_we, cpu_gnt, cpu_ack;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       dma_req, dma_we, dma_gnt, dma_ack;
    logic [7:0] dma_addr, dma_wdata, dma_rdata;
    logic       err, mem_en, mem_write, mem_ready;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit       cr, dr, cwe, dwe;
        logic [7:0] ca, da, cd, dd;
        int       lat;
        bit       eo;
        bit       eerr;
        logic [7:0] erd;
    } vec_t;

    typedef struct {
        bit       owner;
        bit       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];
    logic [7:0] mem_model[256];
    int mem_lat = 0;
    int acc_cnt = 0;

    memory_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .err(err), .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Memory responder: asserts mem_ready after mem_lat ACCESS cycles, stores writes.
    always @(negedge clock) begin
        if (mem_en) begin
            mem_ready = (acc_cnt == mem_lat);
            mem_rdata = mem_ready ? mem_model[mem_addr] : 8'h00;
            if (mem_ready && mem_write) mem_model[mem_addr] = mem_wdata;
            acc_cnt++;
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 8'h00;
            acc_cnt   = 0;
        end
    end

    // Completion monitor: every ack cycle pops one scoreboard entry.
    always @(negedge clock) begin
        if (reset && (cpu_ack || dma_ack)) begin
            exp_t e;
            check("ack_exclusive", {31'd0, cpu_ack & dma_ack}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_ack", {31'd0, dma_ack}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("ack_owner", {31'd0, dma_ack}, {31'd0, e.owner});
                check("ack_err", {31'd0, err}, {31'd0, e.err});
                check("ack_rdata", {24'd0, dma_ack ? dma_rdata : cpu_rdata}, {24'd0, e.rdata});
                $display("txn done owner=%s err=%0d rdata=%02h", dma_ack ? "DMA" : "CPU",
                         err, dma_ack ? dma_rdata : cpu_rdata);
            end
        end else if (reset && err) begin
            check("err_without_ack", {31'd0, err}, 32'd0);
        end
    end

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        dma_req = 0; dma_we = 0; dma_addr = 8'h00; dma_wdata = 8'h00;
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] a, d;
        bit         we;
        int         exp_cyc, cyc;
        bit         got;
        cpu_req = v.cr; cpu_we = v.cwe; cpu_addr = v.ca; cpu_wdata = v.cd;
        dma_req = v.dr; dma_we = v.dwe; dma_addr = v.da; dma_wdata = v.dd;
        mem_lat = v.lat;
        sb.push_back('{v.eo, v.eerr, v.erd});
        a  = v.eo ? v.da  : v.ca;
        d  = v.eo ? v.dd  : v.cd;
        we = v.eo ? v.dwe : v.cwe;
        exp_cyc = (v.lat == NEVER) ? TIMEOUT : v.lat + 1;
        step();
        check("access_gnt_owner", {31'd0, v.eo ? dma_gnt : cpu_gnt}, 32'd1);
        check("access_gnt_other", {31'd0, v.eo ? cpu_gnt : dma_gnt}, 32'd0);
        check("access_mem_en", {31'd0, mem_en}, 32'd1);
        check("access_mem_write", {31'd0, mem_write}, {31'd0, we});
        check("access_mem_addr", {24'd0, mem_addr}, {24'd0, a});
        check("access_mem_wdata", {24'd0, mem_wdata}, {24'd0, d});
        // Requests change after latch: must not affect the transaction.
        cpu_req = 0; dma_req = 0; cpu_addr = 8'hFF; dma_addr = 8'hFF;
        cpu_wdata = 8'hEE; dma_wdata = 8'hEE; cpu_we = ~v.cwe; dma_we = ~v.dwe;
        cyc = 0;
        got = 0;
        while (!got && cyc < 40) begin
            step();
            cyc++;
            if (v.eo ? dma_ack : cpu_ack) begin
                got = 1;
            end else begin
                check("hold_mem_en", {31'd0, mem_en}, 32'd1);
                check("hold_mem_addr", {24'd0, mem_addr}, {24'd0, a});
                check("hold_mem_wdata", {24'd0, mem_wdata}, {24'd0, d});
                check("hold_mem_write", {31'd0, mem_write}, {31'd0, we});
            end
        end
        check("ack_seen", {31'd0, got}, 32'd1);
        check("ack_latency", cyc, exp_cyc);
        check("resp_gnt_owner", {31'd0, v.eo ? dma_gnt : cpu_gnt}, 32'd1);
        check("resp_gnt_other", {31'd0, v.eo ? cpu_gnt : dma_gnt}, 32'd0);
        check("resp_ack_other", {31'd0, v.eo ? cpu_ack : dma_ack}, 32'd0);
        check("resp_mem_en", {31'd0, mem_en}, 32'd0);
        step();
        check("idle_gnts", {30'd0, cpu_gnt, dma_gnt}, 32'd0);
        check("idle_acks", {30'd0, cpu_ack, dma_ack}, 32'd0);
        clear_inputs();
    endtask

    initial begin
        int ack_step[4];
        int nack;
        bit exp_owner;

        // cr dr cwe dwe  ca     da     cd     dd     lat    eo eerr erd
        vecs[0]  = '{1, 0, 0, 0, 8'h10, 8'h00, 8'h00, 8'h00, 0,     0, 0, 8'hA5};
        vecs[1]  = '{0, 1, 0, 1, 8'h00, 8'h20, 8'h00, 8'h3C, 4,     1, 0, 8'h00};
        vecs[2]  = '{0, 1, 0, 0, 8'h00, 8'h20, 8'h00, 8'h00, 1,     1, 0, 8'h3C};
        vecs[3]  = '{1, 1, 0, 0, 8'h30, 8'h40, 8'h00, 8'h00, 0,     0, 0, 8'hCF};
        vecs[4]  = '{1, 1, 1, 0, 8'h40, 8'h10, 8'h11, 8'h00, 2,     1, 0, 8'hA5};
        vecs[5]  = '{1, 0, 1, 0, 8'h50, 8'h00, 8'h77, 8'h00, 0,     0, 0, 8'hCF};
        vecs[6]  = '{1, 0, 0, 0, 8'h50, 8'h00, 8'h00, 8'h00, 3,     0, 0, 8'h77};
        vecs[7]  = '{1, 0, 0, 0, 8'h60, 8'h00, 8'h00, 8'h00, NEVER, 0, 1, 8'h00};
        vecs[8]  = '{0, 1, 0, 0, 8'h00, 8'h40, 8'h00, 8'h00, 0,     1, 0, 8'hBF};
        vecs[9]  = '{1, 1, 1, 0, 8'h40, 8'h50, 8'h11, 8'h00, 0,     0, 0, 8'h00};
        vecs[10] = '{1, 0, 0, 0, 8'h40, 8'h00, 8'h00, 8'h00, 0,     0, 0, 8'h11};
        vecs[11] = '{0, 1, 0, 0, 8'h00, 8'h70, 8'h00, 8'h00, 14,    1, 0, 8'h8F};

        for (int i = 0; i < 256; i++) mem_model[i] = ~8'(i);
        mem_model[8'h10] = 8'hA5;

        clear_inputs();
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
        reset = 1'b0;
        step();
        step();
        check("rst_gnts", {30'd0, cpu_gnt, dma_gnt}, 32'd0);
        check("rst_acks_err", {29'd0, cpu_ack, dma_ack, err}, 32'd0);
        check("rst_mem_ctl", {30'd0, mem_en, mem_write}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_rdata", {16'd0, cpu_rdata, dma_rdata}, 32'd0);
        reset = 1'b1;
        step();

        foreach (vecs[i]) begin
            $display("vector %0d: cpu_req=%0d dma_req=%0d lat=%0d", i, vecs[i].cr, vecs[i].dr, vecs[i].lat);
            run_vec(vecs[i]);
        end

        // Both requests held from reset release: CPU, DMA, CPU, DMA, 3 cycles apart.
        reset = 1'b0;
        cpu_req = 1; dma_req = 1; cpu_addr = 8'h10; dma_addr = 8'h20;
        mem_lat = 0;
        step();
        step();
        for (int k = 0; k < 4; k++) sb.push_back('{k[0], 1'b0, (k[0] ? 8'h3C : 8'hA5)});
        reset = 1'b1;
        nack = 0;
        for (int n = 1; n <= 20 && nack < 4; n++) begin
            step();
            if (cpu_ack || dma_ack) begin
                exp_owner = nack[0];
                check("rr_owner", {31'd0, dma_ack}, {31'd0, exp_owner});
                ack_step[nack] = n;
                nack++;
            end
        end
        clear_inputs();
        check("rr_ack_count", nack, 4);
        check("rr_first_ack", ack_step[0], 2);
        for (int k = 1; k < 4; k++) check("rr_ack_spacing", ack_step[k] - ack_step[k-1], 3);
        step();
        step();

        // Reset asserted in the second ACCESS cycle abandons the transaction.
        cpu_req = 1; cpu_addr = 8'h10; cpu_wdata = 8'h5A; mem_lat = 5;
        step();
        cpu_req = 0;
        step();
        check("mid_access_mem_en", {31'd0, mem_en}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'd0);
        check("abort_mem_ctl", {30'd0, mem_en, mem_write}, 32'd0);
        check("abort_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("abort_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("abort_rdata", {16'd0, cpu_rdata, dma_rdata}, 32'd0);
        check("abort_ack_err", {29'd0, cpu_ack, dma_ack, err}, 32'd0);
        step();
        step();
        check("abort_ack_err_held", {29'd0, cpu_ack, dma_ack, err}, 32'd0);
        reset = 1'b1;
        step();
        run_vec(vecs[0]);

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
